etapa_busqueda: RTL

Instruction fetch stage directly upstream of the immediate sign-extension/decode logic. Holds the program counter, fetches one 32-bit instruction at a time over a request/acknowledge instruction-memory port with variable latency, and presents the instruction and its PC to decode with a valid/ready handshake. Supports redirection (branch/jump) at any time, including while a memory access is outstanding.

---
 rtl/etapa_busqueda_pkg.sv | 19 +
 rtl/etapa_busqueda_registro_pc.sv | 29 ++
 rtl/etapa_busqueda.sv | 121 ++++++++++++
 3 files changed

// File: rtl/etapa_busqueda_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM states, the reset PC, the NOP filler and the PC increment.
package etapa_busqueda_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } estado_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  function automatic logic [31:0] alinear(input logic [31:0] dir);
    return dir & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/etapa_busqueda_registro_pc.sv
// Program counter register: synchronous reset, load of a redirect target,
// or increment by one instruction word. Low two bits are always zero.
module registro_pc
  import etapa_busqueda_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  input  logic        i_load,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  // A load wins over an increment; a redirect always carries the newest target.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= alinear(i_target);
    end else if (i_inc) begin
      r_pc <= r_pc + PC_INC;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// a single holding slot towards decode, and redirect at any point of a fetch.
module etapa_busqueda
  import etapa_busqueda_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruccion_o,
  output logic [31:0] pc_o
);

  estado_t     r_estado;
  estado_t     w_estado_sig;
  logic [31:0] w_pc;
  logic [31:0] r_addr_vuelo;
  logic [31:0] r_instruccion;
  logic [31:0] r_pc_instr;
  logic        r_valid;
  logic        w_req;
  logic        w_ack;
  logic        w_inc;
  logic        w_load;
  logic        w_capturar;
  logic        w_limpiar;
  logic        w_latch;

  registro_pc u_registro_pc (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_inc    (w_inc),
    .i_load   (w_load),
    .i_target (redirect_pc_i),
    .o_pc     (w_pc)
  );

  assign w_req = ((r_estado == FETCH) || (r_estado == DRAIN)) && !rst_i;
  // An ack without an active request belongs to an abandoned access.
  assign w_ack = mem_ack_i && w_req;

  always_comb begin
    w_estado_sig = r_estado;
    w_inc        = 1'b0;
    w_load       = 1'b0;
    w_capturar   = 1'b0;
    w_limpiar    = 1'b0;
    w_latch      = 1'b0;
    case (r_estado)
      FETCH: begin
        if (redirect_i) begin
          w_load = 1'b1;
          if (!w_ack) begin
            w_latch      = 1'b1;
            w_estado_sig = DRAIN;
          end
        end else if (w_ack) begin
          w_capturar   = 1'b1;
          w_inc        = 1'b1;
          w_estado_sig = HOLD;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          w_load       = 1'b1;
          w_limpiar    = 1'b1;
          w_estado_sig = FETCH;
        end else if (instr_ready_i) begin
          w_limpiar    = 1'b1;
          w_estado_sig = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_i) begin
          w_load = 1'b1;
        end
        if (w_ack) begin
          w_estado_sig = FETCH;
        end
      end
      default: w_estado_sig = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_estado      <= FETCH;
      r_addr_vuelo  <= RESET_PC;
      r_instruccion <= NOP;
      r_pc_instr    <= RESET_PC;
      r_valid       <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_latch) begin
        r_addr_vuelo <= w_pc;
      end
      if (w_capturar) begin
        r_instruccion <= mem_rdata_i;
        r_pc_instr    <= w_pc;
        r_valid       <= 1'b1;
      end else if (w_limpiar) begin
        r_instruccion <= NOP;
        r_valid       <= 1'b0;
      end
    end
  end

  assign mem_req_o     = w_req;
  assign mem_addr_o    = rst_i ? RESET_PC :
                         (r_estado == DRAIN) ? r_addr_vuelo : w_pc;
  assign instr_valid_o = r_valid;
  assign instruccion_o = r_instruccion;
  assign pc_o          = r_pc_instr;

endmodule
